// File: rtl/uop_pkg.sv
// Shared constants, entry layout and latency helper for the uop issue queue.
package uop_pkg;

  localparam int UOP_W_DEFAULT = 32;
  localparam int LAT_W_DEFAULT = 6;

  typedef struct packed {
    logic [UOP_W_DEFAULT-1:0] payload;
    logic [LAT_W_DEFAULT-1:0] lat;
  } uop_entry_t;

  // A zero latency is meaningless for issue timing, so it is promoted to one cycle.
  function automatic logic [31:0] eff_lat(input logic [31:0] lat);
    return (lat == 32'd0) ? 32'd1 : lat;
  endfunction

endpackage

// File: rtl/uop_fifo.sv
// Circular buffer of issue entries with a combinational head read.
module uop_fifo #(
  parameter int W     = 38,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clr,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !clr;
  assign do_pop  = pop && !clr;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointers are DEPTH-sized (power of two), so plain increment wraps.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;
  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);

endmodule

// File: rtl/uop_issue_q.sv
// Buffered uop issue stage: FIFO in front of a registered output with per-uop
// issue latency, two-way back-pressure, flush and freeze.
module uop_issue_q
  import uop_pkg::*;
#(
  parameter int UOP_W = UOP_W_DEFAULT,
  parameter int DEPTH = 4,
  parameter int LAT_W = LAT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enabled,
  input  logic             prev_valid,
  input  logic [UOP_W-1:0] prev_uop,
  input  logic [LAT_W-1:0] prev_lat,
  output logic             stalled,
  input  logic             next_stalled,
  output logic             valid,
  output logic [UOP_W-1:0] uop_out,
  output logic [LAT_W-1:0] lat_out,
  output logic             busy
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = UOP_W + LAT_W;

  logic [ENT_W-1:0] fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LAT_W-1:0] prev_lat_eff;
  logic             push;
  logic             cons;
  logic             ld;

  logic             valid_reg;
  logic [UOP_W-1:0] uop_out_reg;
  logic [LAT_W-1:0] lat_out_reg;
  logic [LAT_W-1:0] busy_cnt_reg;
  logic [LAT_W-1:0] busy_cnt_next;

  assign prev_lat_eff = LAT_W'(eff_lat(32'(prev_lat)));

  // No bypass on a full FIFO: a pop in the same cycle does not open a slot.
  assign stalled = (fifo_count == CNT_W'(DEPTH)) || !enabled || clear;
  assign push    = prev_valid && !stalled && !fifo_full;
  assign cons    = valid_reg && !next_stalled && enabled && !clear;

  always_comb begin
    busy_cnt_next = busy_cnt_reg;
    if (enabled) begin
      if (cons) begin
        busy_cnt_next = (lat_out_reg == '0) ? '0 : lat_out_reg - LAT_W'(1);
      end else if (busy_cnt_reg != '0) begin
        busy_cnt_next = busy_cnt_reg - LAT_W'(1);
      end
    end
  end

  // A load is allowed on the edge after which the unit is free, so a lat-L uop
  // consumed at edge t lets the next one load at edge t+L-1 (same edge for L=1).
  assign ld = enabled && !clear && !fifo_empty && (busy_cnt_next == '0) &&
              (!valid_reg || cons);

  uop_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (ld),
    .clr   (clear),
    .din   ({prev_uop, prev_lat_eff}),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // busy_cnt survives a clear: an in-flight multi-cycle op still owns the unit.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg    <= 1'b0;
      uop_out_reg  <= '0;
      lat_out_reg  <= '0;
      busy_cnt_reg <= '0;
    end else begin
      busy_cnt_reg <= busy_cnt_next;
      if (clear) begin
        valid_reg <= 1'b0;
      end else if (ld) begin
        valid_reg   <= 1'b1;
        uop_out_reg <= fifo_head[ENT_W-1:LAT_W];
        lat_out_reg <= fifo_head[LAT_W-1:0];
      end else if (cons) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign valid   = valid_reg;
  assign uop_out = uop_out_reg;
  assign lat_out = lat_out_reg;
  assign busy    = (busy_cnt_reg != '0);

endmodule
